// File: rtl/cordic_pkg.sv
// Shared constants and types for the CORDIC rotation-direction controller.
// Angles are Q2.30 signed radians; the table holds round(atan(2^-i) * 2^30).
package cordic_pkg;

    localparam int LUT_DEPTH = 30;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // atan(2^-i) in Q2.30; beyond i=15 the value is an exact power of two
    function automatic logic [31:0] atan_lut(input logic [4:0] idx);
        logic [31:0] v;
        case (idx)
            5'd0:    v = 32'h3243F6A9;
            5'd1:    v = 32'h1DAC6705;
            5'd2:    v = 32'h0FADBAFD;
            5'd3:    v = 32'h07F56EA7;
            5'd4:    v = 32'h03FEAB77;
            5'd5:    v = 32'h01FFD55C;
            5'd6:    v = 32'h00FFFAAB;
            5'd7:    v = 32'h007FFF55;
            5'd8:    v = 32'h003FFFEB;
            5'd9:    v = 32'h001FFFFD;
            5'd10:   v = 32'h00100000;
            5'd11:   v = 32'h00080000;
            5'd12:   v = 32'h00040000;
            5'd13:   v = 32'h00020000;
            5'd14:   v = 32'h00010000;
            5'd15:   v = 32'h00008000;
            5'd16:   v = 32'h00004000;
            5'd17:   v = 32'h00002000;
            5'd18:   v = 32'h00001000;
            5'd19:   v = 32'h00000800;
            5'd20:   v = 32'h00000400;
            5'd21:   v = 32'h00000200;
            5'd22:   v = 32'h00000100;
            5'd23:   v = 32'h00000080;
            5'd24:   v = 32'h00000040;
            5'd25:   v = 32'h00000020;
            5'd26:   v = 32'h00000010;
            5'd27:   v = 32'h00000008;
            5'd28:   v = 32'h00000004;
            5'd29:   v = 32'h00000002;
            default: v = 32'h00000000;
        endcase
        return v;
    endfunction

    // Total reachable angle of the full table; evaluated at elaboration
    function automatic logic signed [31:0] atan_total();
        logic signed [31:0] s;
        s = '0;
        for (int k = 0; k < LUT_DEPTH; k++) begin
            s = s + $signed(atan_lut(5'(k)));
        end
        return s;
    endfunction

    localparam logic signed [31:0] ATAN_SUM = atan_total();

endpackage

// File: rtl/cordic_angle_acc.sv
// Angle accumulator: holds z_acc, steps it by +/-atan(2^-idx) and reports
// whether the accumulated angle is still at or below the target.
module cordic_angle_acc
    import cordic_pkg::*;
#(
    parameter int W  = 32,
    parameter int IW = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr,
    input  logic                step,
    input  logic                add,
    input  logic [IW-1:0]       idx,
    input  logic signed [W-1:0] target,
    output logic signed [W-1:0] z_next,
    output logic                le
);

    logic signed [W-1:0] z_acc;
    logic signed [W-1:0] delta;

    // Candidate next angle and the direction compare (equality counts as "add")
    always_comb begin
        delta  = $signed(atan_lut(idx));
        z_next = add ? (z_acc + delta) : (z_acc - delta);
        le     = (z_acc <= target);
    end

    // Accumulator register: cleared on a new operation, advanced on each accepted step
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            z_acc <= '0;
        end else if (clr) begin
            z_acc <= '0;
        end else if (step) begin
            z_acc <= z_next;
        end
    end

endmodule

// File: rtl/cordic_dir_ctrl.sv
// Iterative CORDIC rotation-direction controller. One direction bit per
// iteration is handed to the rotation datapath over a valid/ready handshake;
// the residual angle and an out-of-range flag are reported with done.
module cordic_dir_ctrl
    import cordic_pkg::*;
#(
    parameter int ITER = 16,
    parameter int W    = 32,
    parameter int IW   = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [W-1:0]  target,
    output logic          ready,
    output logic          busy,
    output logic          dir_valid,
    input  logic          dir_ready,
    output logic          dir,
    output logic [IW-1:0] iter_idx,
    output logic          done,
    output logic [W-1:0]  residual,
    output logic          range_err
);

    localparam logic [IW-1:0] LAST_IDX = IW'(ITER - 1);

    state_t              state, state_nxt;
    logic signed [W-1:0] target_reg;
    logic signed [W-1:0] z_next;
    logic [IW-1:0]       iter_cnt;
    logic                le;
    logic                start_ok;
    logic                accept;
    logic                last;

    assign start_ok = (state == IDLE) && start;
    assign accept   = (state == RUN) && dir_ready;
    assign last     = (iter_cnt == LAST_IDX);
    assign iter_idx = iter_cnt;

    cordic_angle_acc #(
        .W  (W),
        .IW (IW)
    ) u_acc (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (start_ok),
        .step   (accept),
        .add    (le),
        .idx    (iter_cnt),
        .target (target_reg),
        .z_next (z_next),
        .le     (le)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: DONE always lasts exactly one cycle
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (dir_ready && last) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output decode; dir follows the held compare so it cannot change during a stall
    always_comb begin
        ready     = 1'b0;
        busy      = 1'b0;
        dir_valid = 1'b0;
        done      = 1'b0;
        dir       = 1'b0;
        case (state)
            IDLE: ready = 1'b1;
            RUN: begin
                busy      = 1'b1;
                dir_valid = 1'b1;
                dir       = le;
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    // Target latch, iteration counter and end-of-operation results
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            target_reg <= '0;
            iter_cnt   <= '0;
            residual   <= '0;
            range_err  <= 1'b0;
        end else begin
            if (start_ok) begin
                target_reg <= $signed(target);
                iter_cnt   <= '0;
            end else if (accept && !last) begin
                iter_cnt <= iter_cnt + IW'(1);
            end
            // Captured from the post-update angle so they are valid in the DONE cycle
            if (accept && last) begin
                residual  <= target_reg - z_next;
                range_err <= (target_reg > ATAN_SUM) || (target_reg < -ATAN_SUM);
            end
        end
    end

endmodule

// File: tb/tb_cordic_dir_ctrl.sv
// Self-checking bench for cordic_dir_ctrl. Expected directions, residual and
// range flag come from a real-valued atan reference and plain 32-bit arithmetic.
module tb_cordic_dir_ctrl;

    localparam int ITER = 16;
    localparam int W    = 32;
    localparam int IW   = 5;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [W-1:0]  target;
    logic          ready;
    logic          busy;
    logic          dir_valid;
    logic          dir_ready;
    logic          dir;
    logic [IW-1:0] iter_idx;
    logic          done;
    logic [W-1:0]  residual;
    logic          range_err;

    int n_cmp = 0;
    int n_err = 0;

    logic signed [31:0] a [30];
    logic signed [31:0] asum;
    longint             sum_iter;

    cordic_dir_ctrl #(
        .ITER (ITER),
        .W    (W),
        .IW   (IW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .target    (target),
        .ready     (ready),
        .busy      (busy),
        .dir_valid (dir_valid),
        .dir_ready (dir_ready),
        .dir       (dir),
        .iter_idx  (iter_idx),
        .done      (done),
        .residual  (residual),
        .range_err (range_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, ".ready"},     ready,     1);
        check({tag, ".busy"},      busy,      0);
        check({tag, ".dir_valid"}, dir_valid, 0);
        check({tag, ".dir"},       dir,       0);
        check({tag, ".done"},      done,      0);
    endtask

    // One operation: start, walk the iterations with optional stalls and an
    // optional ignored start pulse, then check done, residual and range_err.
    task automatic run_op(input logic [31:0] tgt, input int stall_at, input int stall_len,
                          input int stall_pct, input int pulse_at, input string name);
        logic signed [31:0] z;
        logic signed [31:0] t;
        logic signed [31:0] r;
        logic [31:0]        exp_res;
        bit                 exp_dir [ITER];
        bit                 exp_rerr;
        bit                 in_range;
        bit                 stall;
        bit                 done_seen;
        int                 i;
        int                 stalls;
        int                 fixed_stalls;
        int                 cyc;
        int                 budget;

        t = tgt;
        z = '0;
        for (int k = 0; k < ITER; k++) begin
            exp_dir[k] = (z <= t);
            z = exp_dir[k] ? z + a[k] : z - a[k];
        end
        exp_res  = t - z;
        exp_rerr = (t > asum) || (t < -asum);
        in_range = (longint'(t) <= sum_iter) && (longint'(t) >= -sum_iter);

        @(negedge clk);
        check({name, ".ready_pre"}, ready, 1);
        start     = 1'b1;
        target    = tgt;
        dir_ready = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        target = $urandom;
        cyc          = 1;
        i            = 0;
        stalls       = 0;
        fixed_stalls = 0;
        done_seen    = 0;
        budget       = ITER + stall_len + 60;

        while (!done_seen && cyc < budget) begin
            if (i < ITER) begin
                check($sformatf("%s.valid%0d", name, i), dir_valid, 1);
                check($sformatf("%s.busy%0d",  name, i), busy, 1);
                check($sformatf("%s.rdy%0d",   name, i), ready, 0);
                check($sformatf("%s.done%0d",  name, i), done, 0);
                check($sformatf("%s.idx%0d",   name, i), iter_idx, i);
                check($sformatf("%s.dir%0d",   name, i), dir, exp_dir[i]);
                stall = 0;
                if (i == stall_at && fixed_stalls < stall_len) begin
                    stall = 1;
                    fixed_stalls++;
                end else if (stalls < 40 && $urandom_range(99) < stall_pct) begin
                    stall = 1;
                end
                start     = (i == pulse_at);
                target    = start ? (tgt ^ 32'h1234_5678) : $urandom;
                dir_ready = !stall;
                if (stall) stalls++;
                else       i++;
            end else begin
                start = 1'b0;
                check({name, ".done"},      done,      1);
                check({name, ".done_rdy"},  ready,     0);
                check({name, ".done_busy"}, busy,      0);
                check({name, ".done_vld"},  dir_valid, 0);
                check({name, ".latency"},   cyc,       ITER + 1 + stalls);
                check({name, ".residual"},  residual,  exp_res);
                check({name, ".range_err"}, range_err, exp_rerr);
                if (in_range) begin
                    r = residual;
                    if (r < 0) r = -r;
                    check({name, ".res_bound"}, (r <= a[ITER-1]), 1);
                end
                done_seen = 1;
                dir_ready = 1'b1;
            end
            @(negedge clk);
            cyc++;
        end
        if (!done_seen) begin
            check({name, ".timeout"}, 0, 1);
        end else begin
            check({name, ".post_rdy"},  ready,    1);
            check({name, ".post_done"}, done,     0);
            check({name, ".post_res"},  residual, exp_res);
        end
    endtask

    initial begin
        logic [31:0] tv;
        longint      tot;
        int          k;

        // Reference table straight from atan, rounded to Q2.30
        tot = 0;
        sum_iter = 0;
        for (int j = 0; j < 30; j++) begin
            a[j] = $rtoi($atan(1.0 / (2.0 ** j)) * 1073741824.0 + 0.5);
            tot += longint'(a[j]);
            if (j < ITER) sum_iter += longint'(a[j]);
        end
        asum = tot[31:0];

        rst_n     = 1'b0;
        start     = 1'b0;
        target    = '0;
        dir_ready = 1'b1;
        #23;
        check_idle_outputs("reset");
        check("reset.iter_idx",  iter_idx,  0);
        check("reset.residual",  residual,  0);
        check("reset.range_err", range_err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_idle_outputs("idle");

        // Directed cases
        run_op(32'h0000_0000, -1, 0, 0, -1, "zero");
        run_op(32'h3243_F6A9, -1, 0, 0, -1, "equal");
        run_op(32'h7FFF_FFFF, -1, 0, 0, -1, "max");
        run_op(32'h8000_0000, -1, 0, 0, -1, "min");
        run_op(32'h2000_0000,  5, 3, 0, -1, "stall");
        run_op(32'hE123_4567, -1, 0, 0,  4, "pulse");

        // Reset in the middle of an operation
        @(negedge clk);
        start  = 1'b1;
        target = 32'h1111_1111;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (iter_idx != 5'd7 && k < 30) begin
            @(negedge clk);
            k++;
        end
        check("midrst.reach7", iter_idx, 7);
        rst_n = 1'b0;
        #1;
        check_idle_outputs("midrst");
        check("midrst.iter_idx",  iter_idx,  0);
        check("midrst.residual",  residual,  0);
        check("midrst.range_err", range_err, 0);
        @(negedge clk);
        check("midrst.no_done", done, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst.no_done2", done, 0);
        run_op(32'h1111_1111, -1, 0, 0, -1, "after_rst");

        // Randomized operations with random backpressure
        for (int n = 0; n < 10; n++) begin
            if (n % 2 == 0) begin
                tv = 32'($urandom_range(0, 32'(2 * sum_iter)) - sum_iter);
            end else begin
                tv = $urandom;
            end
            run_op(tv, -1, 0, 30, (n % 3 == 0) ? 7 : -1, $sformatf("rnd%0d", n));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
